// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - operand stack push/pop controller, initiator on the DataMemory port
// Optional peek (read top without popping) is enabled by defining STACK_PEEK_EN.
module stack_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int BASE   = 0,
  parameter int DEPTH  = 256
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     clr_err,
`ifdef STACK_PEEK_EN
  input  logic                     peek,
`endif
  output logic                     ready,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid,
  output logic [ADDR_W:0]          depth,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf_err,
  output logic                     unf_err,
  output logic                     col_err,
  output logic                     mem_EN,
  output logic [ADDR_W-1:0]        mem_ADDR,
  output logic signed [DATA_W-1:0] mem_in,
  input  logic signed [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {IDLE, PUSH, POP_RD, POP_CAP} state_t;

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_S   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   DEPTH_S = (ADDR_W+1)'(DEPTH);

  state_t                     state, state_n;
  logic [ADDR_W:0]            sp, sp_n;
  logic                       mem_en_n;
  logic [ADDR_W-1:0]          mem_addr_n;
  logic signed [DATA_W-1:0]   mem_in_n;
  logic signed [DATA_W-1:0]   dout_n;
  logic                       dout_valid_n;
  logic                       ovf_n, unf_n, col_n;
  logic                       peek_i;
  logic                       multi_req;
  logic [ADDR_W-1:0]          top_addr;
  logic [ADDR_W-1:0]          slot_addr;

`ifdef STACK_PEEK_EN
  assign peek_i = peek;
`else
  assign peek_i = 1'b0;
`endif

  assign ready = (state == IDLE);
  assign depth = sp;
  assign full  = (sp == DEPTH_S);
  assign empty = (sp == '0);

  // top_addr is the next free slot, slot_addr the current top entry (modulo 2^ADDR_W)
  assign top_addr  = BASE_A + sp[ADDR_W-1:0];
  assign slot_addr = top_addr - ONE_A;
  assign multi_req = (push & pop) | (peek_i & (push | pop));

  always_comb begin
    state_n      = state;
    sp_n         = sp;
    mem_en_n     = 1'b0;
    mem_addr_n   = mem_ADDR;
    mem_in_n     = mem_in;
    dout_n       = dout;
    dout_valid_n = 1'b0;
    // a new error condition in the same cycle as clr_err overrides the clear
    ovf_n        = ovf_err & ~clr_err;
    unf_n        = unf_err & ~clr_err;
    col_n        = col_err & ~clr_err;

    case (state)
      IDLE: begin
        if (multi_req) begin
          col_n = 1'b1;
        end else if (push) begin
          if (full) begin
            ovf_n = 1'b1;
          end else begin
            mem_en_n   = 1'b1;
            mem_addr_n = top_addr;
            mem_in_n   = din;
            sp_n       = sp + ONE_S;
            state_n    = PUSH;
          end
        end else if (pop || peek_i) begin
          if (empty) begin
            unf_n = 1'b1;
          end else begin
            mem_addr_n = slot_addr;
            if (pop) sp_n = sp - ONE_S;
            state_n    = POP_RD;
          end
        end
      end
      PUSH:    state_n = IDLE;
      POP_RD:  state_n = POP_CAP;
      POP_CAP: begin
        dout_n       = mem_out;
        dout_valid_n = 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      sp         <= '0;
      mem_EN     <= 1'b0;
      mem_ADDR   <= '0;
      mem_in     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf_err    <= 1'b0;
      unf_err    <= 1'b0;
      col_err    <= 1'b0;
    end else begin
      state      <= state_n;
      sp         <= sp_n;
      mem_EN     <= mem_en_n;
      mem_ADDR   <= mem_addr_n;
      mem_in     <= mem_in_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      ovf_err    <= ovf_n;
      unf_err    <= unf_n;
      col_err    <= col_n;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - scoreboard bench for stack_ctrl with a registered-read data memory
module tb_stack_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b0;
  logic                     push = 1'b0;
  logic                     pop = 1'b0;
  logic signed [DATA_W-1:0] din = '0;
  logic                     clr_err = 1'b0;
`ifdef STACK_PEEK_EN
  logic                     peek = 1'b0;
`endif
  logic                     ready;
  logic signed [DATA_W-1:0] dout;
  logic                     dout_valid;
  logic [ADDR_W:0]          depth;
  logic                     full, empty, ovf_err, unf_err, col_err, mem_EN;
  logic [ADDR_W-1:0]        mem_ADDR;
  logic signed [DATA_W-1:0] mem_in;
  logic signed [DATA_W-1:0] mem_out = '0;

  logic signed [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  stack_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE(0), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .push(push), .pop(pop), .din(din), .clr_err(clr_err),
`ifdef STACK_PEEK_EN
    .peek(peek),
`endif
    .ready(ready), .dout(dout), .dout_valid(dout_valid), .depth(depth),
    .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err), .col_err(col_err),
    .mem_EN(mem_EN), .mem_ADDR(mem_ADDR), .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_EN) mem[mem_ADDR] <= mem_in;
    mem_out <= mem[mem_ADDR];
  end

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int data; int cyc; } rd_t;
  wr_t wq[$];
  rd_t dq[$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor: every memory write and every dout_valid pulse must match an expectation
  always @(negedge CLK) begin
    if (RST) begin
      if (mem_EN) begin
        if (wq.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("write_addr", int'(mem_ADDR), w.addr);
          check("write_data", int'(mem_in), w.data);
          check("write_cycle", cyc, w.cyc);
        end
      end
      if (dout_valid) begin
        if (dq.size() == 0) begin
          check("unexpected_dout_valid", 1, 0);
        end else begin
          rd_t r;
          r = dq.pop_front();
          check("dout_value", int'(dout), r.data);
          check("dout_cycle", cyc, r.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!ready && k < 20) begin
      tick();
      k++;
    end
    check(tag, int'(ready), 1);
  endtask

  task automatic do_push(input int v, input int exp_addr);
    wait_ready("ready_before_push");
    push = 1'b1;
    din  = DATA_W'(v);
    tick();
    push = 1'b0;
    wq.push_back('{addr: exp_addr, data: v, cyc: cyc});
    check("busy_after_push", int'(ready), 0);
  endtask

  task automatic do_pop(input int v, input bit expect_out);
    wait_ready("ready_before_pop");
    pop = 1'b1;
    tick();
    pop = 1'b0;
    if (expect_out) dq.push_back('{data: v, cyc: cyc + 2});
  endtask

  task automatic pulse(input bit pu, input bit po, input bit clr);
    push = pu; pop = po; clr_err = clr;
    tick();
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    int hold_addr;
    tick();
    tick();
    check("rst_ready", int'(ready), 1);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_depth", int'(depth), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_mem_en", int'(mem_EN), 0);
    check("rst_mem_addr", int'(mem_ADDR), 0);
    check("rst_mem_in", int'(mem_in), 0);
    check("rst_errs", int'({ovf_err, unf_err, col_err}), 0);
    RST = 1'b1;
    tick();

    do_push(456, 0);
    wait_ready("ready_after_push");
    check("depth_after_push", int'(depth), 1);
    check("empty_after_push", int'(empty), 0);

    do_push(-7, 1);
    do_push(1000, 2);
    do_pop(1000, 1);
    do_pop(-7, 1);
    do_pop(456, 1);
    wait_ready("ready_after_pops");
    check("empty_after_pops", int'(empty), 1);
    check("depth_after_pops", int'(depth), 0);

    do_push(10, 0);
    do_push(20, 1);
    do_push(30, 2);
    do_push(40, 3);
    wait_ready("ready_full");
    check("full_at_4", int'(full), 1);
    check("depth_at_4", int'(depth), 4);
    pulse(1, 0, 0);
    check("ovf_set", int'(ovf_err), 1);
    check("depth_after_ovf", int'(depth), 4);
    check("ready_after_ovf", int'(ready), 1);
    pulse(0, 0, 1);
    check("ovf_cleared", int'(ovf_err), 0);
    pulse(1, 0, 1);
    check("ovf_set_wins", int'(ovf_err), 1);
    pulse(0, 0, 1);
    check("ovf_cleared2", int'(ovf_err), 0);
    do_pop(40, 1);
    do_pop(30, 1);
    do_pop(20, 1);
    do_pop(10, 1);
    wait_ready("ready_drained");
    check("empty_drained", int'(empty), 1);

    hold_addr = int'(mem_ADDR);
    pulse(0, 1, 0);
    check("unf_set", int'(unf_err), 1);
    check("addr_held_unf", int'(mem_ADDR), hold_addr);
    check("depth_unf", int'(depth), 0);
    check("ready_unf", int'(ready), 1);
    do_push(5, 0);
    wait_ready("ready_before_col");
    pulse(1, 1, 0);
    check("col_set", int'(col_err), 1);
    check("depth_col", int'(depth), 1);
    check("ovf_not_set", int'(ovf_err), 0);
    pulse(0, 0, 1);
    check("errs_cleared", int'({ovf_err, unf_err, col_err}), 0);
    do_pop(5, 1);

    do_push(77, 0);
    do_push(88, 1);
    do_pop(88, 0);
    RST = 1'b0;
    #1;
    check("midrst_mem_en", int'(mem_EN), 0);
    check("midrst_mem_addr", int'(mem_ADDR), 0);
    check("midrst_depth", int'(depth), 0);
    check("midrst_ready", int'(ready), 1);
    check("midrst_dout_valid", int'(dout_valid), 0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    tick();
    tick();
    do_push(99, 0);
    do_pop(99, 1);
    wait_ready("ready_after_rst_pop");

`ifdef STACK_PEEK_EN
    do_push(-32768, 0);
    wait_ready("ready_before_peek");
    peek = 1'b1;
    tick();
    peek = 1'b0;
    dq.push_back('{data: -32768, cyc: cyc + 2});
    wait_ready("ready_peek1");
    peek = 1'b1;
    tick();
    peek = 1'b0;
    dq.push_back('{data: -32768, cyc: cyc + 2});
    wait_ready("ready_peek2");
    check("depth_after_peek", int'(depth), 1);
`endif

    tick();
    tick();
    check("writes_outstanding", wq.size(), 0);
    check("reads_outstanding", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
